// File: rtl/vt_sense_seq.sv
// Measurement sequencer for the ring-oscillator ripple-counter VT sensor.
// Runs 2^AVG_LOG2 gated count windows per request (clear, enable, settle,
// capture), accumulates the captured counts and publishes their average.
module vt_sense_seq #(
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned CLR_CYC    = 2,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic        CLK,
    input  logic        RSTLOW,
    input  logic        START,
    input  logic        ABORT,
    input  logic [15:0] WINDOW,
    input  logic [15:0] CNT,
    output logic        ENIN,
    output logic        RSTLOW_CNT,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] RESULT
);

    localparam int unsigned AccW = 16 + AVG_LOG2;
    localparam int unsigned SmpW = AVG_LOG2 + 1;
    localparam logic [SmpW-1:0] SmpLast    = SmpW'((1 << AVG_LOG2) - 1);
    localparam logic [15:0]     ClrLast    = 16'(CLR_CYC - 1);
    localparam logic [15:0]     SettleLast = 16'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {StIdle, StClr, StEn, StSettle, StCapt, StFin} state_e;

    state_e          state_q, state_d;
    logic [15:0]     cyc_q, cyc_d;
    logic [15:0]     win_q, win_d;
    logic [SmpW-1:0] smp_q, smp_d;
    logic [AccW-1:0] acc_q, acc_d;
    logic [AccW-1:0] acc_sum;
    logic [15:0]     result_q, result_d;
    logic            enin_q, rstlow_cnt_q, busy_q, done_q;

    // State, cycle counter, window, sample counter and accumulator registers.
    always_ff @(posedge CLK or negedge RSTLOW) begin
        if (!RSTLOW) begin
            state_q  <= StIdle;
            cyc_q    <= '0;
            win_q    <= '0;
            smp_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            win_q    <= win_d;
            smp_q    <= smp_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // Next-state logic: each timed phase ends when cyc_q reaches its last cycle.
    always_comb begin
        acc_sum  = acc_q + AccW'(CNT);
        state_d  = state_q;
        cyc_d    = cyc_q + 16'd1;
        win_d    = win_q;
        smp_d    = smp_q;
        acc_d    = acc_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                cyc_d = '0;
                if (START) begin
                    state_d = StClr;
                    win_d   = WINDOW;
                    acc_d   = '0;
                    smp_d   = '0;
                end
            end
            StClr: begin
                if (cyc_q == ClrLast) begin
                    cyc_d   = '0;
                    // A zero-length window never raises the enable.
                    state_d = (win_q == 16'd0) ? StSettle : StEn;
                end
            end
            StEn: begin
                if (cyc_q == win_q - 16'd1) begin
                    cyc_d   = '0;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (cyc_q == SettleLast) begin
                    cyc_d   = '0;
                    state_d = StCapt;
                end
            end
            StCapt: begin
                cyc_d = '0;
                acc_d = acc_sum;
                smp_d = smp_q + SmpW'(1);
                if (smp_q == SmpLast) begin
                    state_d  = StFin;
                    // Result is ready in the FIN cycle, alongside DONE.
                    result_d = 16'(acc_sum >> AVG_LOG2);
                end else begin
                    state_d = StClr;
                end
            end
            StFin: begin
                cyc_d   = '0;
                state_d = StIdle;
            end
            default: begin
                cyc_d   = '0;
                state_d = StIdle;
            end
        endcase
        // Abort overrides every transition outside IDLE and discards the run.
        if (ABORT && (state_q != StIdle)) begin
            state_d  = StIdle;
            cyc_d    = '0;
            acc_d    = '0;
            smp_d    = '0;
            result_d = result_q;
        end
    end

    // Outputs registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK or negedge RSTLOW) begin
        if (!RSTLOW) begin
            enin_q       <= 1'b0;
            rstlow_cnt_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            enin_q       <= (state_d == StEn);
            rstlow_cnt_q <= (state_d != StClr);
            busy_q       <= (state_d != StIdle);
            done_q       <= (state_d == StFin);
        end
    end

    assign ENIN       = enin_q;
    assign RSTLOW_CNT = rstlow_cnt_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign RESULT     = result_q;

endmodule

// File: doc/vt_sense_seq.md
# vt_sense_seq

Measurement sequencer for the ring-oscillator ripple-counter VT sensor. It sits directly upstream of the ripple counter stage: it drives the counter's enable (ENIN) and counter reset (RSTLOW_CNT), and it reads back the counter's 16-bit CNT output. For each request it runs 2^AVG_LOG2 gated measurement windows timed on the reference clock, lets the ripple chain settle, accumulates the samples and publishes their average as RESULT.

## Interface
- AVG_LOG2, default 2: log2 of the number of windows averaged; legal 0..4.
- CLR_CYC, default 2: cycles RSTLOW_CNT is held low before each window; legal ≥1.
- SETTLE_CYC, default 4: cycles waited after ENIN falls before CNT is sampled; legal ≥2.

Ports:
- CLK, input, 1: reference clock. One clock domain only.
- RSTLOW, input, 1: reset, asynchronous, active-low.
- START, input, 1: request pulse. Sampled only in IDLE.
- ABORT, input, 1: synchronous abort. Honoured in every state except IDLE.
- WINDOW, input, 16: number of CLK cycles ENIN is high per window. Captured on START.
- CNT, input, 16: count value from the ripple counter.
- ENIN, output, 1: counter enable; registered and glitch-free.
- RSTLOW_CNT, output, 1: active-low counter clear; registered.
- BUSY, output, 1: high while a measurement is in progress.
- DONE, output, 1: one-cycle pulse when RESULT updates.
- RESULT, output, 16: averaged count; held until the next DONE.

## Operation
- Reset values while RSTLOW=0:
  - ENIN=0, RSTLOW_CNT=0 (the counter is held clear), BUSY=0, DONE=0, RESULT=0.
  - State returns to IDLE; the accumulator and all internal counters are cleared.
- State machine: IDLE → CLR → EN → SETTLE → CAPT → (CLR | FIN) → IDLE.
- IDLE:
  - RSTLOW_CNT=1, so the last count stays readable.
  - START=1 latches WINDOW into win_q, clears the accumulator and sample counter, and moves to CLR.
- CLR: RSTLOW_CNT=0 for exactly CLR_CYC cycles, then EN.
- EN:
  - ENIN=1 for exactly win_q cycles, then SETTLE.
  - If win_q=0, EN is skipped (CLR → SETTLE) and ENIN never rises.
- SETTLE: ENIN=0 for SETTLE_CYC cycles, covering ripple propagation and synchroniser-free sampling of a static CNT.
- CAPT (1 cycle):
  - acc ← acc + CNT. The accumulator is 16+AVG_LOG2 bits wide and cannot overflow.
  - The sample counter increments. If it has reached 2^AVG_LOG2 the next state is FIN, otherwise CLR.
- FIN (1 cycle):
  - RESULT ← acc >> AVG_LOG2 (truncating), DONE=1, then IDLE.
- BUSY is 1 in every state except IDLE, including the FIN cycle.
- START while BUSY=1 is ignored (not queued).
- ABORT:
  - Next cycle: IDLE, ENIN=0, RSTLOW_CNT=1.
  - No DONE pulse; RESULT is unchanged; the accumulator is discarded.
  - ABORT takes priority over every other transition.
- START and ABORT asserted together in IDLE: START wins, because ABORT has no effect in IDLE.
- Counter wrap: a counter wrap inside a window is not detected. Software sizes WINDOW so that fRO/fCLK × WINDOW < 65536.

## Timing
- All outputs are registered from CLK.
- START is sampled high at edge 0:
  - Edge 0: state becomes CLR; RSTLOW_CNT is low during cycles 1..CLR_CYC.
  - ENIN is high during cycles CLR_CYC+1 .. CLR_CYC+win_q.
  - CAPT is cycle CLR_CYC+win_q+SETTLE_CYC+1.
- Per-sample period: P = CLR_CYC + win_q + SETTLE_CYC + 1 cycles.
- DONE is high in cycle N·P+1, where N = 2^AVG_LOG2. BUSY falls after that cycle.
- With the defaults and WINDOW=100: P=107, DONE in cycle 429.
- CNT is sampled only in CAPT; it is don't-care in every other cycle.
- An async reset asserted mid-operation forces the reset values immediately. Operation resumes in IDLE at the first edge after RSTLOW rises.

## Test plan
- Averaging run:
  - Stimulus: defaults; WINDOW=100; counter model counting 3 per enabled CLK; START pulse.
  - Required: ENIN high for exactly 100 cycles per window, 4 windows, DONE at cycle 429, RESULT=300.
- Truncating average:
  - Stimulus: AVG_LOG2=2; model returns CNT 10, 11, 11, 11.
  - Required: RESULT=10 (43>>2).
- Zero window:
  - Stimulus: WINDOW=0; START.
  - Required: ENIN stays 0 throughout, RESULT=0, DONE at cycle 4·(2+0+4+1)+1 = 29.
- ABORT mid-EN:
  - Stimulus: prior RESULT=300; assert ABORT during the second window.
  - Required: next cycle ENIN=0, BUSY=0, RSTLOW_CNT=1; no DONE; RESULT stays 300.
- START while busy:
  - Stimulus: second START pulse during SETTLE; WINDOW changed to 50.
  - Required: the run is unaffected, with the full 100-cycle windows and a single DONE.
- Async reset:
  - Stimulus: RSTLOW=0 mid-CAPT, between edges.
  - Required: immediately ENIN=0, RSTLOW_CNT=0, BUSY=0, RESULT=0. After release, a fresh START completes normally.
